// File: rtl/crypto1_key_collector.sv
// Collects found keys from an array of Crypto1 search cores: round-robin scan of KEY_VALID,
// serial 48-bit readout over the selected core's KEY_CLK/KEY_DATA, then a valid/ready handoff.
module crypto1_key_collector #(
   parameter int N_CORES  = 16,
   parameter int CLK_HALF = 2,
   parameter int IDX_W    = $clog2(N_CORES)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [N_CORES-1:0] i_core_done,
   input  logic [N_CORES-1:0] i_core_key_valid,
   input  logic [N_CORES-1:0] i_core_key_data,
   output logic [N_CORES-1:0] o_core_key_clk,
   output logic [47:0]        o_key,
   output logic [IDX_W-1:0]   o_key_core,
   output logic               o_key_out_valid,
   input  logic               i_key_out_ready,
   output logic [7:0]         o_key_count,
   output logic               o_all_done
);

   typedef enum logic [1:0] {
      S_SCAN,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_PRESENT
   } state_t;

   localparam logic [3:0]       PHASE_LAST = 4'(CLK_HALF - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CORES - 1);
   localparam logic [5:0]       LAST_BIT   = 6'd47;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_sel;
   logic [N_CORES-1:0] r_serviced;
   logic [47:0]        r_sr;
   logic [5:0]         r_bitcnt;
   logic [3:0]         r_phase;
   logic [N_CORES-1:0] r_core_key_clk;
   logic [47:0]        r_key;
   logic [IDX_W-1:0]   r_key_core;
   logic               r_key_out_valid;
   logic [7:0]         r_key_count;
   logic               r_all_done;

   logic [N_CORES-1:0] w_pending;
   logic [N_CORES-1:0] w_sel_onehot;
   logic               w_all_done_cond;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // A core counts as pending only until its key has been delivered once.
   assign w_pending       = i_core_key_valid & ~r_serviced;
   assign w_sel_onehot    = N_CORES'(1) << r_sel;
   assign w_all_done_cond = (&i_core_done) & ~(|w_pending);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: every register, including the shift register and the key, is cleared so the
         // host never sees a stale key after a reset that interrupts a shift.
         r_state         <= S_SCAN;
         r_ptr           <= '0;
         r_sel           <= '0;
         r_serviced      <= '0;
         r_sr            <= '0;
         r_bitcnt        <= '0;
         r_phase         <= '0;
         r_core_key_clk  <= '0;
         r_key           <= '0;
         r_key_core      <= '0;
         r_key_out_valid <= 1'b0;
         r_key_count     <= '0;
         r_all_done      <= 1'b0;
      end else begin
         r_all_done <= (r_state == S_SCAN) && w_all_done_cond;

         case (r_state)
            S_SCAN: begin
               if (w_pending[r_ptr]) begin
                  r_sel    <= r_ptr;
                  r_phase  <= '0;
                  r_bitcnt <= '0;
                  r_state  <= S_SHIFT_LO;
               end else begin
                  r_ptr <= next_idx(r_ptr);
               end
            end

            S_SHIFT_LO: begin
               // Data is sampled at the end of the low half, just before KEY_CLK rises.
               if (r_phase == PHASE_LAST) begin
                  r_sr           <= {r_sr[46:0], i_core_key_data[r_sel]};
                  r_phase        <= '0;
                  r_core_key_clk <= w_sel_onehot;
                  r_state        <= S_SHIFT_HI;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end

            S_SHIFT_HI: begin
               if (r_phase == PHASE_LAST) begin
                  r_phase        <= '0;
                  r_core_key_clk <= '0;
                  if (r_bitcnt == LAST_BIT) begin
                     r_key             <= r_sr;
                     r_key_core        <= r_sel;
                     r_key_out_valid   <= 1'b1;
                     r_serviced[r_sel] <= 1'b1;
                     r_state           <= S_PRESENT;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                     r_state  <= S_SHIFT_LO;
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end

            S_PRESENT: begin
               // Resuming after the served core keeps the scan round-robin fair.
               if (i_key_out_ready) begin
                  r_key_out_valid <= 1'b0;
                  if (r_key_count != 8'hFF) r_key_count <= r_key_count + 1'b1;
                  r_ptr   <= next_idx(r_sel);
                  r_state <= S_SCAN;
               end
            end

            default: r_state <= S_SCAN;
         endcase
      end
   end

   assign o_core_key_clk  = r_core_key_clk;
   assign o_key           = r_key;
   assign o_key_core      = r_key_core;
   assign o_key_out_valid = r_key_out_valid;
   assign o_key_count     = r_key_count;
   assign o_all_done      = r_all_done;

endmodule

// File: tb/tb_crypto1_key_collector.sv
// Bench for crypto1_key_collector: behavioural serial cores plus a scoreboard of expected
// deliveries (keys owned by each core, index-ordered service, saturating delivery count).
module tb_crypto1_key_collector;

   localparam int N  = 16;
   localparam int CH = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  done;
   logic [N-1:0]  valid;
   logic [N-1:0]  kdata;
   logic [N-1:0]  kclk;
   logic [47:0]   key;
   logic [3:0]    kcore;
   logic          kov;
   logic          ready;
   logic [7:0]    kcount;
   logic          alldone;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_count = 0;

   logic [47:0] core_key [N];
   int          core_pos [N] = '{default: 0};
   int          rise_cnt [N] = '{default: 0};
   logic [N-1:0] kclk_prev = '0;

   logic [3:0]  q_core [$];
   logic [47:0] q_key  [$];

   always #5 clk = ~clk;

   crypto1_key_collector #(.N_CORES(N), .CLK_HALF(CH)) dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_core_done      (done),
      .i_core_key_valid (valid),
      .i_core_key_data  (kdata),
      .o_core_key_clk   (kclk),
      .o_key            (key),
      .o_key_core       (kcore),
      .o_key_out_valid  (kov),
      .i_key_out_ready  (ready),
      .o_key_count      (kcount),
      .o_all_done       (alldone)
   );

   // Serial core model: presents key bit (47 - pos), advances on each KEY_CLK rise.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (kclk[i] && !kclk_prev[i]) rise_cnt[i] <= rise_cnt[i] + 1;
         if (rst) core_pos[i] <= 0;
         else if (kclk[i] && !kclk_prev[i]) core_pos[i] <= core_pos[i] + 1;
      end
      kclk_prev <= kclk;
   end

   always_comb begin
      kdata = '0;
      for (int i = 0; i < N; i++)
         if (core_pos[i] < 48) kdata[i] = core_key[i][47 - core_pos[i]];
   end

   function automatic logic [47:0] rand_key();
      return {16'($urandom), $urandom};
   endfunction

   function automatic int sum_rises();
      int s = 0;
      for (int i = 0; i < N; i++) s += rise_cnt[i];
      return s;
   endfunction

   task automatic do_reset(input logic [N-1:0] v, input logic [N-1:0] d);
      @(posedge clk); #1;
      rst = 1'b1; valid = v; done = d; ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_count = 0;
      q_core.delete();
      q_key.delete();
   endtask

   // Waits for deliveries, optionally stalling READY, and logs them in the queues.
   task automatic collect(input int n, input int max_hold, input int budget, output int got);
      int c; int d; logic [47:0] k0; logic [3:0] c0; bit stable;
      got = 0; c = 0;
      while (got < n && c < budget) begin
         @(negedge clk); c++;
         if (kov) begin
            k0 = key; c0 = kcore; stable = 1'b1;
            d = (max_hold > 0) ? int'($urandom_range(max_hold, 0)) : 0;
            for (int j = 0; j < d; j++) begin
               @(negedge clk); c++;
               if (key !== k0 || kcore !== c0 || kov !== 1'b1 || kclk !== '0) stable = 1'b0;
            end
            if (d > 0) begin
               n_checks++;
               if (!stable) $display("FAIL hold_stable: core %0d output changed during %0d-cycle stall", c0, d);
               else n_pass++;
            end
            q_core.push_back(c0);
            q_key.push_back(k0);
            ready = 1'b1;
            @(negedge clk); c++;
            ready = 1'b0;
            exp_count = (exp_count < 255) ? exp_count + 1 : 255;
            n_checks++;
            if (kov !== 1'b0 || kcount !== 8'(exp_count))
               $display("FAIL handshake: valid=%0b count=%0d, want valid=0 count=%0d", kov, kcount, exp_count);
            else n_pass++;
            got++;
         end
      end
   endtask

   task automatic test_reset();
      do_reset('0, '0);
      @(negedge clk);
      n_checks++;
      if ({kclk, key, kcore, kov} !== '0)
         $display("FAIL reset_outputs: kclk=%h key=%h core=%0d valid=%0b, want all 0", kclk, key, kcore, kov);
      else n_pass++;
      n_checks++;
      if (kcount !== 8'd0 || alldone !== 1'b0)
         $display("FAIL reset_count: count=%0d all_done=%0b, want 0/0", kcount, alldone);
      else n_pass++;
   endtask

   task automatic test_single_key();
      int t_rise; int t_valid; int r3; int rall;
      logic [47:0] k; logic [3:0] kc;
      do_reset('0, '0);
      core_key[3] = 48'hAD1AEAC63EE3;
      ready = 1'b1;
      r3 = rise_cnt[3]; rall = sum_rises();
      valid[3] = 1'b1;
      t_rise = -1; t_valid = -1; k = '0; kc = '0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (kclk[3] && t_rise < 0) t_rise = c;
         if (kov) begin t_valid = c; k = key; kc = kcore; break; end
      end
      n_checks++;
      if (k !== 48'hAD1AEAC63EE3) $display("FAIL single_key: got %h want ad1aeac63ee3", k);
      else n_pass++;
      n_checks++;
      if (kc !== 4'd3) $display("FAIL single_core: got %0d want 3", kc);
      else n_pass++;
      n_checks++;
      if (t_rise < 0 || t_valid - t_rise !== 2 * 48 * CH - CH)
         $display("FAIL single_latency: first rise->valid %0d cycles, want %0d", t_valid - t_rise, 2 * 48 * CH - CH);
      else n_pass++;
      @(negedge clk);
      ready = 1'b0;
      n_checks++;
      if (kcount !== 8'd1 || kov !== 1'b0) $display("FAIL single_count: count=%0d valid=%0b want 1/0", kcount, kov);
      else n_pass++;
      repeat (4) @(negedge clk);
      n_checks++;
      if (rise_cnt[3] - r3 !== 48 || sum_rises() - rall !== 48)
         $display("FAIL single_pulses: core3=%0d total=%0d want 48/48", rise_cnt[3] - r3, sum_rises() - rall);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int got; bit again;
      core_key[2] = rand_key();
      core_key[5] = rand_key();
      do_reset(16'h0024, '0);
      collect(2, 0, 1500, got);
      n_checks++;
      if (got !== 2) $display("FAIL rr_deliveries: got %0d want 2", got);
      else n_pass++;
      if (got == 2) begin
         n_checks++;
         if (q_core[0] !== 4'd2 || q_core[1] !== 4'd5)
            $display("FAIL rr_order: got %0d,%0d want 2,5", q_core[0], q_core[1]);
         else n_pass++;
         n_checks++;
         if (q_key[0] !== core_key[2] || q_key[1] !== core_key[5])
            $display("FAIL rr_keys: got %h,%h want %h,%h", q_key[0], q_key[1], core_key[2], core_key[5]);
         else n_pass++;
      end
      again = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (kov) again = 1'b1;
      end
      n_checks++;
      if (again || kcount !== 8'd2) $display("FAIL rr_once: redelivered=%0b count=%0d want 0/2", again, kcount);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int rall; bit seen; bit stable; logic [47:0] k0; logic [3:0] c0;
      do_reset('0, '0);
      core_key[9] = rand_key();
      valid[9] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk);
         if (kov) seen = 1'b1;
      end
      n_checks++;
      if (!seen) $display("FAIL bp_valid: no key within 600 cycles");
      else n_pass++;
      k0 = key; c0 = kcore; stable = 1'b1; rall = sum_rises();
      repeat (50) begin
         @(negedge clk);
         if (key !== k0 || kcore !== c0 || kov !== 1'b1 || kclk !== '0 || kcount !== 8'd0) stable = 1'b0;
      end
      n_checks++;
      if (!stable || sum_rises() !== rall) $display("FAIL bp_hold: output moved during 50-cycle stall");
      else n_pass++;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      n_checks++;
      if (kcount !== 8'd1 || kov !== 1'b0 || k0 !== core_key[9] || c0 !== 4'd9)
         $display("FAIL bp_accept: count=%0d valid=%0b key=%h core=%0d want 1/0/%h/9", kcount, kov, k0, c0, core_key[9]);
      else n_pass++;
   endtask

   task automatic test_all_done_no_keys();
      bit seen_done; bit seen_valid;
      do_reset('0, '1);
      seen_done = 1'b0; seen_valid = 1'b0;
      for (int c = 0; c < N + 1; c++) begin
         @(negedge clk);
         if (alldone) seen_done = 1'b1;
      end
      repeat (100) begin
         @(negedge clk);
         if (kov) seen_valid = 1'b1;
      end
      n_checks++;
      if (!seen_done || alldone !== 1'b1) $display("FAIL done_idle: all_done seen=%0b now=%0b want 1/1", seen_done, alldone);
      else n_pass++;
      n_checks++;
      if (seen_valid) $display("FAIL done_no_valid: key valid asserted with no keys");
      else n_pass++;
   endtask

   task automatic test_all_done_pending();
      bit early; bit seen;
      core_key[15] = rand_key();
      do_reset(16'h8000, '1);
      early = 1'b0; seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk);
         if (alldone) early = 1'b1;
         if (kov) seen = 1'b1;
      end
      repeat (10) begin
         @(negedge clk);
         if (alldone) early = 1'b1;
      end
      n_checks++;
      if (!seen || early || kcore !== 4'd15)
         $display("FAIL pend_hold: valid=%0b early_done=%0b core=%0d want 1/0/15", seen, early, kcore);
      else n_pass++;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      n_checks++;
      if (alldone !== 1'b0) $display("FAIL pend_latency: all_done=%0b one cycle early, want 0", alldone);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (alldone !== 1'b1) $display("FAIL pend_done: all_done=%0b after acceptance, want 1", alldone);
      else n_pass++;
   endtask

   task automatic test_reset_mid_shift();
      int got; int r0; bit hit;
      core_key[4] = rand_key();
      core_key[7] = rand_key();
      do_reset('0, '0);
      valid[4] = 1'b1;
      collect(1, 0, 600, got);
      r0 = rise_cnt[7];
      valid[7] = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 1500 && !hit; c++) begin
         @(negedge clk);
         if (rise_cnt[7] - r0 >= 20) hit = 1'b1;
      end
      n_checks++;
      if (!hit || got !== 1) $display("FAIL mid_setup: first=%0d bit20_reached=%0b want 1/1", got, hit);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b1; valid[4] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_count = 0;
      q_core.delete(); q_key.delete();
      @(negedge clk);
      n_checks++;
      if (kclk !== '0 || key !== '0 || kcount !== 8'd0 || kov !== 1'b0)
         $display("FAIL mid_reset: kclk=%h key=%h count=%0d valid=%0b want all 0", kclk, key, kcount, kov);
      else n_pass++;
      collect(1, 0, 600, got);
      n_checks++;
      if (got !== 1 || q_core[0] !== 4'd7 || q_key[0] !== core_key[7])
         $display("FAIL mid_recollect: got=%0d key=%h want core 7 key %h", got, (got > 0) ? q_key[0] : 48'h0, core_key[7]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] v; int n; int got; int k; bit ok;
      for (int it = 0; it < 3; it++) begin
         v = '0;
         while ($countones(v) < 2) v = 16'($urandom) & 16'($urandom);
         for (int i = 0; i < N; i++) core_key[i] = rand_key();
         n = $countones(v);
         do_reset(v, '0);
         collect(n, 6, 300 * n + 200, got);
         ok = (got == n);
         k = 0;
         for (int i = 0; i < N && ok; i++) begin
            if (v[i]) begin
               if (q_core[k] !== 4'(i) || q_key[k] !== core_key[i]) ok = 1'b0;
               k++;
            end
         end
         n_checks++;
         if (!ok) $display("FAIL random_%0d: set %h got %0d of %0d keys or wrong order/value", it, v, got, n);
         else n_pass++;
         n_checks++;
         if (kcount !== 8'(n)) $display("FAIL random_count_%0d: count=%0d want %0d", it, kcount, n);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; valid = '0; done = '0; ready = 1'b0;
      for (int i = 0; i < N; i++) core_key[i] = '0;
      test_reset();
      test_single_key();
      test_round_robin();
      test_backpressure();
      test_all_done_no_keys();
      test_all_done_pending();
      test_reset_mid_shift();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/crypto1_key_collector.md
# crypto1_key_collector

Downstream collection stage for an array of `Crypto1Core` search engines. It scans the cores' `KEY_VALID` flags round-robin and selects one core that holds a found key. It clocks that core's 48-bit key out over the core's serial `KEY_DATA`/`KEY_CLK` port, then presents the key and the core index to the host side with a valid/ready handshake. It also reports when the whole array has finished searching.

## Interface
- `N_CORES`, default 16: number of attached cores (2..256).
- `CLK_HALF`, default 2: CLK cycles per `KEY_CLK` half-period (1..15).
- `IDX_W`, default `$clog2(N_CORES)`: width of the core index.

- `CLK`, in, 1: single clock; all logic on the rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `CORE_DONE`, in, N_CORES: per-core `DONE`.
- `CORE_KEY_VALID`, in, N_CORES: per-core `KEY_VALID`, held high by the core once it has a key.
- `CORE_KEY_DATA`, in, N_CORES: per-core serial key bit, MSB first.
- `CORE_KEY_CLK`, out, N_CORES: per-core serial shift clock.
- `KEY`, out, 48: collected key.
- `KEY_CORE`, out, IDX_W: index of the core that produced `KEY`.
- `KEY_OUT_VALID`, out, 1: `KEY`/`KEY_CORE` valid.
- `KEY_OUT_READY`, in, 1: host accepts.
- `KEY_COUNT`, out, 8: keys delivered, saturating at 255.
- `ALL_DONE`, out, 1: array finished and nothing left to deliver.

## Operation
- States: SCAN, SHIFT_LO, SHIFT_HI, PRESENT.
- Registers: `ptr` (IDX_W), `sel` (IDX_W), `serviced` (N_CORES), shift register `sr` (48), `bitcnt` (6), `phase` (4).

**SCAN**
- Each cycle, examine core `ptr`.
- If `CORE_KEY_VALID[ptr] & ~serviced[ptr]`: set `sel<=ptr`, `phase<=0`, `bitcnt<=0`, go to SHIFT_LO.
- Otherwise: `ptr<=ptr+1`, wrapping from N_CORES-1 to 0.

**SHIFT_LO**
- `CORE_KEY_CLK[sel]=0`; `phase` counts up.
- When `phase==CLK_HALF-1`: set `sr<={sr[46:0],CORE_KEY_DATA[sel]}`, `phase<=0`, go to SHIFT_HI.

**SHIFT_HI**
- `CORE_KEY_CLK[sel]=1`.
- When `phase==CLK_HALF-1`:
  - If `bitcnt==47`: go to PRESENT, `KEY<=sr`, `KEY_CORE<=sel`, `KEY_OUT_VALID<=1`, `serviced[sel]<=1`.
  - Otherwise: `bitcnt++`, go to SHIFT_LO.
- The rising edge of `KEY_CLK` advances the core to its next bit. Bit 0 sampled is `key[47]`.

**PRESENT**
- Hold `KEY`, `KEY_CORE` and `KEY_OUT_VALID` stable until `KEY_OUT_READY`.
- On the cycle with `KEY_OUT_VALID & KEY_OUT_READY`:
  - `KEY_OUT_VALID<=0`; `KEY_COUNT` increments (saturating).
  - `ptr<=sel+1`, with wrap; return to SCAN.
  - This gives round-robin fairness.

**Other rules**
- `CORE_KEY_CLK[i]` is 0 for every `i != sel`, and for all cores outside SHIFT_HI.
- A core whose `KEY_VALID` drops mid-shift is still shifted to completion. Its key is delivered as collected; no abort.
- `ALL_DONE` is registered. It equals `&CORE_DONE & ~|(CORE_KEY_VALID & ~serviced)`, qualified with state==SCAN, and is forced to 0 otherwise.
- `serviced` is cleared only by `RESET`. A core re-raising `KEY_VALID` without a reset is never collected twice.

## Timing
- Reset values: all outputs 0; state SCAN; `ptr=0`; `serviced=0`; `KEY=0`; `KEY_COUNT=0`.
- `RESET` mid-shift returns the block to SCAN next cycle with `CORE_KEY_CLK` all 0. Cores must be reset by the same system reset.
- Scan latency: up to N_CORES cycles from `KEY_VALID` rising to entering SHIFT_LO.
- Shift duration: exactly 96·CLK_HALF cycles from entering SHIFT_LO to `KEY_OUT_VALID` high.
- Data sampling: `CORE_KEY_DATA` is sampled on the last SHIFT_LO cycle, CLK_HALF cycles after the preceding `KEY_CLK` fall. Cores must present data within CLK_HALF-1 cycles of that fall.
- PRESENT to SCAN: 1 cycle after the handshake.
- Back-to-back keys: next selection no earlier than 1 cycle after acceptance.
- Simultaneous valid cores are served in index order starting from `ptr`.
- `ALL_DONE` latency: 1 cycle after its condition holds in SCAN.

## Test plan
- **Single key:** core 3 raises `KEY_VALID` with serial key 0xAD1AEAC63EE3, CLK_HALF=2, `READY=1` -> `KEY=0xAD1AEAC63EE3`, `KEY_CORE=3`, `KEY_COUNT=1`, 192 cycles SHIFT_LO→valid, exactly 48 `KEY_CLK` pulses on core 3 only.
- **Round-robin:** cores 5 and 2 raise valid in the same cycle, `ptr=0` -> core 2 delivered first, then core 5. Each key is delivered once; `KEY_COUNT=2`.
- **Backpressure:** `READY` low for 50 cycles after valid -> `KEY`/`KEY_CORE`/valid stable for all 50 cycles; no `KEY_CLK` activity; count increments only on acceptance.
- **All done, no keys:** all `CORE_DONE=1`, no valid -> `ALL_DONE=1` within N_CORES+1 cycles, `KEY_OUT_VALID` never asserted.
- **All done with pending key:** all done, core 15 holds valid -> `ALL_DONE` stays 0 until core 15's key is accepted, then goes to 1.
- **Reset mid-shift:** `RESET` at bit 20 -> next cycle `CORE_KEY_CLK=0`, `KEY=0`, `KEY_COUNT=0`, state SCAN; after re-raise, the full key is collected correctly from bit 47.
